// File: rtl/cpu_mem_loader.sv
// cpu_mem_loader: loads a program into instruction memory, runs the cpu for a set
// number of cycles, then streams a data-memory window back out.
module cpu_mem_loader #(
  parameter int DATA_W    = 32,
  parameter int CNT_W     = 16,
  parameter int ADDR_STEP = 4,
  parameter int RD_LAT    = 1
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              start,
  input  logic [CNT_W-1:0]  prog_words,
  input  logic [CNT_W-1:0]  run_cycles,
  input  logic [31:0]       dump_base,
  input  logic [CNT_W-1:0]  dump_words,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              cpu_enable,
  output logic [31:0]       addr_ext,
  output logic              wen_ext,
  output logic              ren_ext,
  output logic [DATA_W-1:0] wdata_ext,
  input  logic [DATA_W-1:0] rdata_ext,
  output logic [31:0]       addr_ext_2,
  output logic              wen_ext_2,
  output logic              ren_ext_2,
  output logic [DATA_W-1:0] wdata_ext_2,
  input  logic [DATA_W-1:0] rdata_ext_2,
  output logic              busy,
  output logic              done
);
  localparam int LW = RD_LAT > 1 ? $clog2(RD_LAT) : 1;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_RD, S_WAIT, S_OUT, S_DONE} state_t;
  state_t            r_state, w_next;
  logic [CNT_W-1:0]  r_prog, r_run, r_dump, r_cnt, w_cnt_nx;
  logic [31:0]       r_load_ptr, r_dump_ptr;
  logic [DATA_W-1:0] r_out_data;
  logic [LW-1:0]     r_wait;
  logic              w_acc, w_hs, w_inc, w_wait_end, w_clr, w_unused;
  assign w_acc      = r_state == S_LOAD && in_valid;
  assign w_hs       = r_state == S_OUT && out_ready;
  assign w_inc      = w_acc || w_hs || r_state == S_RUN;
  assign w_cnt_nx   = r_cnt + CNT_W'(1);
  assign w_wait_end = r_wait == LW'(RD_LAT - 1);
  // the counter is shared: per-word in LOAD/DUMP, per-cycle in RUN, so clear it between phases
  assign w_clr      = w_next != r_state && (r_state == S_IDLE || r_state == S_LOAD || r_state == S_RUN);
  assign w_unused   = ^rdata_ext;
  always_ff @(posedge clk or posedge arst) begin
    if (arst) r_state <= S_IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = prog_words != '0 ? S_LOAD : S_RUN;
      S_LOAD:  if (w_acc && w_cnt_nx == r_prog) w_next = S_RUN;
      S_RUN:   if (r_cnt == r_run) w_next = r_dump != '0 ? S_RD : S_DONE;
      S_RD:    w_next = S_WAIT;
      S_WAIT:  if (w_wait_end) w_next = S_OUT;
      S_OUT:   if (w_hs) w_next = w_cnt_nx == r_dump ? S_DONE : S_RD;
      default: w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_prog     <= '0;
      r_run      <= '0;
      r_dump     <= '0;
      r_cnt      <= '0;
      r_load_ptr <= '0;
      r_dump_ptr <= '0;
      r_out_data <= '0;
      r_wait     <= '0;
    end else begin
      if (r_state == S_IDLE && start) begin
        r_prog     <= prog_words;
        r_run      <= run_cycles;
        r_dump     <= dump_words;
        r_load_ptr <= '0;
        r_dump_ptr <= dump_base;
      end
      if (w_acc) r_load_ptr <= r_load_ptr + 32'(ADDR_STEP);
      if (w_hs) r_dump_ptr <= r_dump_ptr + 32'(ADDR_STEP);
      r_cnt  <= w_clr ? '0 : (w_inc ? w_cnt_nx : r_cnt);
      r_wait <= r_state == S_WAIT ? r_wait + LW'(1) : '0;
      if (r_state == S_WAIT && w_wait_end) r_out_data <= rdata_ext_2;
    end
  end
  always_comb begin
    in_ready    = r_state == S_LOAD;
    wen_ext     = w_acc;
    addr_ext    = w_acc ? r_load_ptr : '0;
    wdata_ext   = w_acc ? in_data : '0;
    ren_ext     = 1'b0;
    cpu_enable  = r_state == S_RUN && r_cnt != r_run;
    ren_ext_2   = r_state == S_RD;
    addr_ext_2  = r_state == S_RD ? r_dump_ptr : '0;
    wen_ext_2   = 1'b0;
    wdata_ext_2 = '0;
    out_valid   = r_state == S_OUT;
    out_data    = r_out_data;
    busy        = r_state != S_IDLE;
    done        = r_state == S_DONE;
  end
endmodule

// File: tb/tb_cpu_mem_loader.sv
// tb_cpu_mem_loader: directed load/run/dump sequences against a synchronous
// data-memory model whose word at address a reads as 0xA5A50000 ^ a.
module tb_cpu_mem_loader;
  logic        clk = 0, arst = 1, start = 0, clr = 0, gap_mode = 0, rdy_mode = 0;
  logic [15:0] prog_words = 0, run_cycles = 0, dump_words = 0;
  logic [31:0] dump_base = 0, rdata_ext = 0, rdata_ext_2 = 0;
  logic [31:0] in_data, out_data, addr_ext, wdata_ext, addr_ext_2, wdata_ext_2;
  logic        in_valid, in_ready, out_valid, out_ready, cpu_enable;
  logic        wen_ext, ren_ext, wen_ext_2, ren_ext_2, busy, done;
  int n_tests = 0, n_fail = 0;

  cpu_mem_loader dut (
    .clk(clk), .arst(arst), .start(start), .prog_words(prog_words), .run_cycles(run_cycles),
    .dump_base(dump_base), .dump_words(dump_words), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .cpu_enable(cpu_enable), .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext),
    .wdata_ext(wdata_ext), .rdata_ext(rdata_ext), .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2),
    .ren_ext_2(ren_ext_2), .wdata_ext_2(wdata_ext_2), .rdata_ext_2(rdata_ext_2),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [31:0] prog [0:7] = '{32'h20010005, 32'h20020007, 32'h00221820, 32'h11111111,
                              32'h22222222, 32'h33333333, 32'h44444444, 32'h55555555};
  logic [3:0]  rpat = 4'b1001;
  logic        tog = 0;
  int          wr_idx = 0, rcnt = 0;
  assign in_valid  = gap_mode ? ~tog : 1'b1;
  assign in_data   = prog[wr_idx[2:0]];
  assign out_ready = rdy_mode ? rpat[rcnt[1:0]] : 1'b1;

  always @(posedge clk) begin
    tog    <= in_ready ? ~tog : 1'b0;
    wr_idx <= start ? 0 : wr_idx + (wen_ext ? 1 : 0);
    rcnt   <= start ? 0 : rcnt + (out_valid ? 1 : 0);
    if (ren_ext_2) rdata_ext_2 <= 32'hA5A50000 ^ addr_ext_2;
  end

  int n_wen = 0, n_en = 0, n_en_rise = 0, n_ren = 0, n_hs = 0, n_done = 0, n_rdy = 0;
  int e_excl = 0, e_stall = 0, e_seq = 0, e_gap = 0;
  logic [31:0] wa [16], wd [16], ra [16], od [16];
  logic        p_ov = 0, p_or = 0, p_en = 0;
  logic [31:0] p_od = 0;

  always @(negedge clk) begin
    if (clr) begin
      n_wen = 0; n_en = 0; n_en_rise = 0; n_ren = 0; n_hs = 0; n_done = 0; n_rdy = 0;
      e_excl = 0; e_stall = 0; e_seq = 0; e_gap = 0;
    end else begin
      if (wen_ext) begin
        if (n_wen < 16) begin wa[n_wen] = addr_ext; wd[n_wen] = wdata_ext; end
        if (!in_valid) e_gap++;
        n_wen++;
      end
      if (ren_ext_2) begin
        if (n_ren != n_hs) e_seq++;
        if (n_ren < 16) ra[n_ren] = addr_ext_2;
        n_ren++;
      end
      if (out_valid && out_ready) begin
        if (n_hs < 16) od[n_hs] = out_data;
        n_hs++;
      end
      if (p_ov && !p_or && (!out_valid || out_data != p_od)) e_stall++;
      if (int'(wen_ext) + int'(ren_ext_2) + int'(cpu_enable) > 1 || ren_ext || wen_ext_2 || wdata_ext_2 != 0) e_excl++;
      if (cpu_enable) n_en++;
      if (cpu_enable && !p_en) n_en_rise++;
      if (in_ready) n_rdy++;
      if (done) n_done++;
    end
    p_ov = out_valid; p_or = out_ready; p_od = out_data; p_en = cpu_enable;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic start_seq(input logic [15:0] pw, rc, input logic [31:0] db, input logic [15:0] dw);
    @(posedge clk); #1 clr = 1;
    @(negedge clk); #1 clr = 0;
    prog_words = pw; run_cycles = rc; dump_base = db; dump_words = dw; start = 1;
    @(posedge clk); #1 start = 0;
  endtask

  task automatic wait_done(input int limit, output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (!done && n < limit);
    check("done_seen", {31'd0, done}, 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_enable();
    int k = 0;
    while (!cpu_enable && k < 100) begin @(negedge clk); k++; end
    check("enable_seen", {31'd0, cpu_enable}, 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, {25'd0, cpu_enable, in_ready, out_valid, wen_ext, ren_ext_2, busy, done}, 0);
    check({tag, "_addr"}, addr_ext | addr_ext_2, 0);
    check({tag, "_odata"}, out_data, 0);
  endtask

  initial begin
    int n;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1 arst = 0;

    start_seq(3, 10, 0, 2);
    wait_done(200, n);
    check("t1_nwen", n_wen, 3);
    check("t1_wa0", wa[0], 0); check("t1_wa1", wa[1], 4); check("t1_wa2", wa[2], 8);
    check("t1_wd0", wd[0], 32'h20010005); check("t1_wd1", wd[1], 32'h20020007);
    check("t1_wd2", wd[2], 32'h00221820);
    check("t1_nen", n_en, 10); check("t1_enrise", n_en_rise, 1);
    check("t1_nren", n_ren, 2); check("t1_ra1", ra[1], 4);
    check("t1_nhs", n_hs, 2);
    check("t1_od0", od[0], 32'hA5A50000); check("t1_od1", od[1], 32'hA5A50004);
    check("t1_ndone", n_done, 1); check("t1_nrdy", n_rdy, 3);
    check("t1_excl", e_excl, 0); check("t1_busy", {31'd0, busy}, 0);

    rdy_mode = 1;
    start_seq(1, 2, 32'h10, 3);
    wait_done(200, n);
    rdy_mode = 0;
    check("t2_nren", n_ren, 3);
    check("t2_ra0", ra[0], 32'h10); check("t2_ra1", ra[1], 32'h14); check("t2_ra2", ra[2], 32'h18);
    check("t2_nhs", n_hs, 3);
    check("t2_od0", od[0], 32'hA5A50010); check("t2_od1", od[1], 32'hA5A50014);
    check("t2_od2", od[2], 32'hA5A50018);
    check("t2_stall", e_stall, 0); check("t2_seq", e_seq, 0); check("t2_excl", e_excl, 0);

    gap_mode = 1;
    start_seq(3, 1, 0, 1);
    wait_done(200, n);
    gap_mode = 0;
    check("t3_nwen", n_wen, 3);
    check("t3_wa1", wa[1], 4); check("t3_wa2", wa[2], 8);
    check("t3_wd1", wd[1], 32'h20020007);
    check("t3_nrdy", n_rdy, 5); check("t3_gap", e_gap, 0);

    start_seq(0, 0, 0, 0);
    wait_done(50, n);
    check("t4_latency", n, 2);
    check("t4_nwen", n_wen, 0); check("t4_nen", n_en, 0); check("t4_nren", n_ren, 0);
    check("t4_nrdy", n_rdy, 0); check("t4_ndone", n_done, 1);

    start_seq(1, 10, 0, 1);
    wait_enable();
    @(posedge clk); #1 prog_words = 5; run_cycles = 3; dump_words = 4; start = 1;
    @(posedge clk); #1 start = 0;
    wait_done(200, n);
    check("t5_nen", n_en, 10); check("t5_nwen", n_wen, 1);
    check("t5_nhs", n_hs, 1); check("t5_ndone", n_done, 1); check("t5_ra0", ra[0], 0);

    start_seq(1, 10, 0, 1);
    wait_enable();
    repeat (4) @(posedge clk);
    #3 arst = 1;
    #1 check_all_zero("t6_rst");
    @(posedge clk); #1 arst = 0;
    start_seq(2, 3, 8, 2);
    wait_done(200, n);
    check("t6_nwen", n_wen, 2); check("t6_wa1", wa[1], 4);
    check("t6_nen", n_en, 3);
    check("t6_od0", od[0], 32'hA5A50008); check("t6_od1", od[1], 32'hA5A5000C);
    check("t6_ndone", n_done, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end
endmodule
